cam_cmd_ctrl: RTL and testbench

//   Command sequencer in front of the 16x8 CAM. Accepts LOOKUP/INSERT/DELETE/FLUSH

---
 rtl/cam_cmd_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_cam_cmd_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_cmd_ctrl.sv
// Command sequencer for a 16x8 CAM: serialises LOOKUP/INSERT/DELETE/FLUSH, tracks
// per-entry valid bits, allocates the lowest free entry and returns status/index.
module cam_cmd_ctrl #(
    parameter int DEPTH = 16,
    parameter int KW    = 8,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [KW-1:0] cmd_key,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [2:0]    rsp_status,
    output logic [AW-1:0] rsp_index,
    output logic [KW-1:0] cam_srch_data,
    input  logic          cam_found,
    input  logic [AW-1:0] cam_srch_addr,
    output logic          cam_wr_en,
    output logic [AW-1:0] cam_wr_addr,
    output logic [KW-1:0] cam_wr_data,
    output logic [AW:0]   occupancy,
    output logic          full
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] SRCH = 3'd1;
    localparam logic [2:0] EXEC = 3'd2;
    localparam logic [2:0] CLR  = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_FLUSH  = 2'b11;

    localparam logic [2:0] ST_OK        = 3'd0;
    localparam logic [2:0] ST_NOT_FOUND = 3'd1;
    localparam logic [2:0] ST_DUPLICATE = 3'd2;
    localparam logic [2:0] ST_FULL      = 3'd3;
    localparam logic [2:0] ST_BAD_KEY   = 3'd4;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_OCC = (AW + 1)'(DEPTH);

    logic [2:0]       state_reg;
    logic [1:0]       op_reg;
    logic [KW-1:0]    key_reg;
    logic             found_reg;
    logic [AW-1:0]    addr_reg;
    logic [AW-1:0]    idx_reg;
    logic [DEPTH-1:0] valid_reg;
    logic [AW:0]      occupancy_reg;
    logic [AW:0]      occupancy_next;
    logic             full_reg;
    logic [2:0]       rsp_status_reg;
    logic [AW-1:0]    rsp_index_reg;
    logic [KW-1:0]    srch_data_reg;

    logic [AW-1:0]    alloc_idx;
    logic [2:0]       exec_status;
    logic [AW-1:0]    exec_index;
    logic             ins_wr;
    logic             del_wr;
    logic             exec_active;
    logic             clr_active;
    logic             clr_last;

    assign exec_active = (state_reg == EXEC);
    assign clr_active  = (state_reg == CLR);
    assign clr_last    = clr_active && (idx_reg == LAST_IDX);

    // Lowest-index free slot; scanning downward lets the lowest index win.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                alloc_idx = AW'(i);
            end
        end
    end

    always_comb begin
        exec_status = ST_OK;
        exec_index  = '0;
        ins_wr      = 1'b0;
        del_wr      = 1'b0;
        if (key_reg == '0) begin
            exec_status = ST_BAD_KEY;
        end else begin
            case (op_reg)
                OP_LOOKUP: begin
                    if (found_reg) begin
                        exec_index = addr_reg;
                    end else begin
                        exec_status = ST_NOT_FOUND;
                    end
                end
                OP_INSERT: begin
                    if (found_reg) begin
                        exec_status = ST_DUPLICATE;
                        exec_index  = addr_reg;
                    end else if (full_reg) begin
                        exec_status = ST_FULL;
                    end else begin
                        ins_wr     = 1'b1;
                        exec_index = alloc_idx;
                    end
                end
                OP_DELETE: begin
                    if (found_reg) begin
                        del_wr     = 1'b1;
                        exec_index = addr_reg;
                    end else begin
                        exec_status = ST_NOT_FOUND;
                    end
                end
                default: begin
                    exec_status = ST_OK;
                end
            endcase
        end
    end

    // Write port is driven straight from state so the CAM, valid bits and
    // occupancy all update on the same edge.
    always_comb begin
        cam_wr_en   = 1'b0;
        cam_wr_addr = '0;
        cam_wr_data = '0;
        if (clr_active) begin
            cam_wr_en   = 1'b1;
            cam_wr_addr = idx_reg;
        end else if (exec_active && ins_wr) begin
            cam_wr_en   = 1'b1;
            cam_wr_addr = alloc_idx;
            cam_wr_data = key_reg;
        end else if (exec_active && del_wr) begin
            cam_wr_en   = 1'b1;
            cam_wr_addr = addr_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            logic set_v;
            logic clr_v;
            assign set_v = exec_active && ins_wr && (alloc_idx == AW'(gi));
            assign clr_v = (exec_active && del_wr && (addr_reg == AW'(gi))) ||
                           (clr_active && (idx_reg == AW'(gi)));
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (set_v) begin
                    valid_reg[gi] <= 1'b1;
                end else if (clr_v) begin
                    valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        occupancy_next = occupancy_reg;
        if (clr_last) begin
            occupancy_next = '0;
        end else if (exec_active && ins_wr) begin
            occupancy_next = occupancy_reg + 1'b1;
        end else if (exec_active && del_wr) begin
            occupancy_next = occupancy_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy_reg <= '0;
            full_reg      <= 1'b0;
        end else begin
            occupancy_reg <= occupancy_next;
            full_reg      <= (occupancy_next == FULL_OCC);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            op_reg         <= OP_LOOKUP;
            key_reg        <= '0;
            found_reg      <= 1'b0;
            addr_reg       <= '0;
            idx_reg        <= '0;
            rsp_status_reg <= ST_OK;
            rsp_index_reg  <= '0;
            srch_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        op_reg  <= cmd_op;
                        key_reg <= cmd_key;
                        if (cmd_op == OP_FLUSH) begin
                            idx_reg   <= '0;
                            state_reg <= CLR;
                        end else begin
                            srch_data_reg <= cmd_key;
                            state_reg     <= SRCH;
                        end
                    end
                end
                SRCH: begin
                    found_reg <= cam_found;
                    addr_reg  <= cam_srch_addr;
                    state_reg <= EXEC;
                end
                EXEC: begin
                    rsp_status_reg <= exec_status;
                    rsp_index_reg  <= exec_index;
                    state_reg      <= RESP;
                end
                CLR: begin
                    idx_reg <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        rsp_status_reg <= ST_OK;
                        rsp_index_reg  <= '0;
                        state_reg      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = (state_reg == IDLE);
    assign rsp_valid     = (state_reg == RESP);
    assign rsp_status    = rsp_status_reg;
    assign rsp_index     = rsp_index_reg;
    assign cam_srch_data = srch_data_reg;
    assign occupancy     = occupancy_reg;
    assign full          = full_reg;

endmodule

// File: tb/tb_cam_cmd_ctrl.sv
// Scoreboard bench for cam_cmd_ctrl with a behavioural 16x8 CAM attached.
module tb_cam_cmd_ctrl;

    localparam logic [1:0] LOOKUP = 2'b00;
    localparam logic [1:0] INSERT = 2'b01;
    localparam logic [1:0] DELETE = 2'b10;
    localparam logic [1:0] FLUSH  = 2'b11;

    localparam logic [2:0] OK = 3'd0, NF = 3'd1, DUP = 3'd2, FUL = 3'd3, BAD = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_key;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_status;
    logic [3:0] rsp_index;
    logic [7:0] cam_srch_data;
    logic       cam_found;
    logic [3:0] cam_srch_addr;
    logic       cam_wr_en;
    logic [3:0] cam_wr_addr;
    logic [7:0] cam_wr_data;
    logic [4:0] occupancy;
    logic       full;

    always #5 clk = ~clk;

    cam_cmd_ctrl #(.DEPTH(16), .KW(8), .AW(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_key(cmd_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_index(rsp_index),
        .cam_srch_data(cam_srch_data), .cam_found(cam_found), .cam_srch_addr(cam_srch_addr),
        .cam_wr_en(cam_wr_en), .cam_wr_addr(cam_wr_addr), .cam_wr_data(cam_wr_data),
        .occupancy(occupancy), .full(full)
    );

    // Behavioural CAM: synchronous write, combinational lowest-index match.
    logic [7:0] cam_mem [16];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) cam_mem[i] <= 8'h00;
        end else if (cam_wr_en) begin
            cam_mem[cam_wr_addr] <= cam_wr_data;
        end
    end
    always_comb begin
        cam_found     = 1'b0;
        cam_srch_addr = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (cam_mem[i] == cam_srch_data) begin
                cam_found     = 1'b1;
                cam_srch_addr = 4'(i);
            end
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] key;
        logic [2:0] st;
        logic [3:0] idx;
        int         acc;
        int         lat;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         c;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_log[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   wr_cnt = 0;
    bit   seen = 1'b0;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && cam_wr_en) begin
            wr_cnt++;
            wr_log.push_back('{cam_wr_addr, cam_wr_data, cyc});
        end
    end

    // Monitor: latency on first sight of a response, fields on the handshake.
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                if (!seen) chk("unexpected_rsp", 1, 0);
                seen = 1'b1;
            end else begin
                if (!seen) begin
                    chk($sformatf("op%0d_key%02h_latency", exp_q[0].op, exp_q[0].key),
                        cyc - exp_q[0].acc, exp_q[0].lat);
                    seen = 1'b1;
                end
                if (rsp_ready) begin
                    $display("rsp op=%0d key=%02h status=%0d index=%0d (exp %0d/%0d)",
                             exp_q[0].op, exp_q[0].key, rsp_status, rsp_index,
                             exp_q[0].st, exp_q[0].idx);
                    chk($sformatf("op%0d_key%02h_status", exp_q[0].op, exp_q[0].key),
                        int'(rsp_status), int'(exp_q[0].st));
                    chk($sformatf("op%0d_key%02h_index", exp_q[0].op, exp_q[0].key),
                        int'(rsp_index), int'(exp_q[0].idx));
                    void'(exp_q.pop_front());
                end
            end
            if (rsp_ready) seen = 1'b0;
        end
    end

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("response_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] key,
                        input logic [2:0] st, input logic [3:0] idx, input bit drain = 1'b1);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_key   = key;
        exp_q.push_back('{op, key, st, idx, cyc + 1, (op == FLUSH) ? 16 : 2});
        @(negedge clk);
        cmd_valid = 1'b0;
        if (drain) wait_drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_status"}, int'(rsp_status), 0);
        chk({tag, "_rsp_index"}, int'(rsp_index), 0);
        chk({tag, "_srch_data"}, int'(cam_srch_data), 0);
        chk({tag, "_wr_en"}, int'(cam_wr_en), 0);
        chk({tag, "_wr_addr"}, int'(cam_wr_addr), 0);
        chk({tag, "_wr_data"}, int'(cam_wr_data), 0);
        chk({tag, "_occupancy"}, int'(occupancy), 0);
        chk({tag, "_full"}, int'(full), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [2:0] st0;
        logic [3:0] ix0;
        int rsp_seen;
        int n;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = LOOKUP;
        cmd_key   = 8'h00;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        w0 = wr_cnt;
        send(INSERT, 8'h5A, OK, 4'd0);
        chk("ins5a_writes", wr_cnt - w0, 1);
        w0 = wr_cnt;
        send(INSERT, 8'h3C, OK, 4'd1);
        chk("ins3c_writes", wr_cnt - w0, 1);
        chk("occ_after_2", int'(occupancy), 2);

        w0 = wr_cnt;
        send(INSERT, 8'h5A, DUP, 4'd0);
        chk("dup_writes", wr_cnt - w0, 0);
        send(LOOKUP, 8'h3C, OK, 4'd1);
        send(LOOKUP, 8'h77, NF, 4'd0);

        send(DELETE, 8'h5A, OK, 4'd0);
        chk("del_cam0", int'(cam_mem[0]), 0);
        chk("occ_after_del", int'(occupancy), 1);
        send(INSERT, 8'h99, OK, 4'd0);
        send(DELETE, 8'h5A, NF, 4'd0);
        chk("occ_after_reuse", int'(occupancy), 2);

        do_reset();
        for (int k = 1; k <= 16; k++) send(INSERT, 8'(k), OK, 4'(k - 1));
        chk("fill_full", int'(full), 1);
        chk("fill_occ", int'(occupancy), 16);
        w0 = wr_cnt;
        send(INSERT, 8'h20, FUL, 4'd0);
        send(LOOKUP, 8'h00, BAD, 4'd0);
        send(INSERT, 8'h00, BAD, 4'd0);
        send(DELETE, 8'h00, BAD, 4'd0);
        chk("full_badkey_writes", wr_cnt - w0, 0);
        chk("still_full", int'(full), 1);

        wr_log.delete();
        w0 = wr_cnt;
        send(FLUSH, 8'h00, OK, 4'd0);
        chk("flush_writes", wr_cnt - w0, 16);
        if (wr_log.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("flush_addr%0d", i), int'(wr_log[i].a), i);
                chk($sformatf("flush_data%0d", i), int'(wr_log[i].d), 0);
                chk($sformatf("flush_cyc%0d", i), wr_log[i].c - wr_log[0].c, i);
            end
        end
        chk("flush_occ", int'(occupancy), 0);
        chk("flush_full", int'(full), 0);
        send(LOOKUP, 8'h01, NF, 4'd0);

        rsp_ready = 1'b0;
        send(INSERT, 8'h42, OK, 4'd0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_rsp_valid", int'(rsp_valid), 1);
        st0 = rsp_status;
        ix0 = rsp_index;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", i), int'(rsp_valid), 1);
            chk($sformatf("stall%0d_status", i), int'(rsp_status), int'(st0));
            chk($sformatf("stall%0d_index", i), int'(rsp_index), int'(ix0));
            chk($sformatf("stall%0d_cmd_ready", i), int'(cmd_ready), 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_drain();

        send(FLUSH, 8'h00, OK, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_outputs("midclr");
        chk("midclr_cam0", int'(cam_mem[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        rsp_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
        end
        chk("midclr_no_rsp", rsp_seen, 0);
        chk("midclr_idle", int'(cmd_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
